nibble_serial_addsub_ctrl: RTL and testbench
============================================

Name: nibble_serial_addsub_ctrl

Overview:
- Sequencer that performs WIDTH-bit two's-complement add/subtract using a single 4-bit add/subtract slice, one nibble per clock, LSB nibble first.
- The carry is chained between nibbles through a register.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready).
- Reports carry, signed overflow and zero flags for the full-width result.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start_valid  input  1  operands and mode presented
- start_ready  output  1  block can accept a new operation
- op_a  input  WIDTH  minuend/augend
- op_b  input  WIDTH  subtrahend/addend
- mode  input  1  0 = A+B, 1 = A-B
- abort  input  1  synchronous cancel of the operation in flight
- busy  output  1  high in RUN or DONE
- res_valid  output  1  result and flags valid
- res_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- carry_out  output  1  carry out of the MSB; for subtraction, 1 = no borrow
- overflow  output  1  signed overflow
- zero  output  1  result == 0

Behaviour:
- One clock; reset is synchronous and active-low. When rst_n = 0 at a clk edge, the following apply:
  - state = IDLE; start_ready = 1.
  - busy, res_valid, carry_out, overflow = 0; zero = 1.
  - result, nibble index and carry register are cleared.
- Reset has priority over everything, including mid-RUN and DONE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid = 1, latch op_a, op_b and mode, set idx = 0 and carry_reg = mode, then go to RUN. abort is ignored in IDLE.
- RUN, each cycle:
  - Slice inputs: a = A[4*idx+3 : 4*idx], b = B nibble XOR {4{mode}}, cin = carry_reg.
  - Write the 4-bit sum into result nibble idx; carry_reg <= slice carry out; idx++.
  - On idx == NIB-1:
    - carry_out <= slice carry out.
    - overflow <= carry into bit 3 XOR carry out of bit 3 of that nibble.
    - zero <= (full result including this nibble) == 0.
    - Go to DONE.
- Latency: with acceptance at edge E0, res_valid = 1 after edge E_NIB (4 cycles for WIDTH = 16).
- DONE:
  - res_valid = 1; result and flags are held stable while res_ready = 0 (unbounded backpressure).
  - res_valid & res_ready → IDLE on the next edge. start_ready returns to 1 only in IDLE; there is no same-cycle turnaround.
- abort = 1 in RUN or DONE → IDLE on the next edge.
  - res_valid drops; no result handshake occurs.
  - result and flags keep their last values but are meaningless.
  - abort has priority over res_ready in DONE.
- Operand registers are not affected by input changes after acceptance.
- Arithmetic is pure modulo 2^WIDTH; flags follow standard two's-complement definitions. For subtraction, carry_out = NOT borrow.

Test Plan:
- Add: A = 0x1234, B = 0x0FFF, mode = 0 → result = 0x2233, carry_out = 0, overflow = 0, zero = 0; res_valid exactly 4 cycles after acceptance.
- Subtract: A = 0x0005, B = 0x0007, mode = 1 → result = 0xFFFE, carry_out = 0, overflow = 0. Also A = B = 0xABCD, mode = 1 → result = 0x0000, zero = 1, carry_out = 1.
- Overflow:
  - A = 0x7FFF + 0x0001 → 0x8000, overflow = 1, carry_out = 0.
  - A = 0x8000 - 0x0001 → 0x7FFF, overflow = 1, carry_out = 1.
  - 0xFFFF + 0x0001 → 0x0000, carry_out = 1, zero = 1, overflow = 0.
- Backpressure: hold res_ready = 0 for 10 cycles → res_valid and result stable, start_ready = 0. Then res_ready = 1 → IDLE next edge; a new op is accepted the following cycle.
- Abort: assert abort on the 2nd RUN cycle → IDLE next edge, res_valid never rises. The next op (0x0001 + 0x0001) returns 0x0002 with correct flags, showing no stale carry.
- Reset mid-operation: rst_n = 0 during RUN and separately during DONE → all outputs at reset values on the next edge. Also check that start_valid while busy is not accepted and op_a changes after acceptance do not alter the result.

Source files
------------

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit two's-complement add/subtract computed one nibble per clock through a
// single 4-bit slice, LSB nibble first, with valid/ready handshakes on both sides.
module nibble_serial_addsub_ctrl #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mode,
  input  logic             abort,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic             r_mode;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carryOut;
  logic             r_overflow;
  logic             r_zero;

  logic [IDX_W+1:0] w_shift;
  logic [3:0]       w_aNib;
  logic [3:0]       w_bNib;
  logic [4:0]       w_sum;
  logic [3:0]       w_low;
  logic             w_c3;
  logic             w_lastNib;
  logic [WIDTH-1:0] w_nextResult;

  // Subtraction is A + ~B + 1: the B nibble is inverted here and the +1 enters
  // as the initial carry loaded at acceptance.
  always_comb begin
    w_shift      = {r_idx, 2'b00};
    w_aNib       = 4'(r_opA >> w_shift);
    w_bNib       = 4'(r_opB >> w_shift) ^ {4{r_mode}};
    w_sum        = {1'b0, w_aNib} + {1'b0, w_bNib} + {4'b0000, r_carry};
    w_low        = {1'b0, w_aNib[2:0]} + {1'b0, w_bNib[2:0]} + {3'b000, r_carry};
    w_c3         = w_low[3];
    w_lastNib    = (r_idx == IDX_W'(NIB - 1));
    w_nextResult = (r_result & ~(WIDTH'(4'hF) << w_shift))
                 | (WIDTH'(w_sum[3:0]) << w_shift);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_opA      <= '0;
      r_opB      <= '0;
      r_mode     <= 1'b0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_result   <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_opA   <= op_a;
            r_opB   <= op_b;
            r_mode  <= mode;
            r_idx   <= '0;
            r_carry <= mode;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_nextResult;
            r_carry  <= w_sum[4];
            if (w_lastNib) begin
              r_idx      <= '0;
              r_carryOut <= w_sum[4];
              r_overflow <= w_c3 ^ w_sum[4];
              r_zero     <= (w_nextResult == '0);
              r_state    <= S_DONE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          // abort wins over a simultaneous result handshake
          if (abort || res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign result      = r_result;
  assign carry_out   = r_carryOut;
  assign overflow    = r_overflow;
  assign zero        = r_zero;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for nibble_serial_addsub_ctrl: vector table plus handshake,
// backpressure, abort and reset corner-case sequences.
module tb_nibble_serial_addsub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        mode;
  logic        abort;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [15:0] expResult;
    logic        expC;
    logic        expV;
    logic        expZ;
  } vec_t;

  vec_t vecs[9];

  nibble_serial_addsub_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .mode        (mode),
    .abort       (abort),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " start_ready"}, 32'(start_ready), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, " result"}, 32'(result), 32'd0);
    checkOutput({tag, " carry_out"}, 32'(carry_out), 32'd0);
    checkOutput({tag, " overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, " zero"}, 32'(zero), 32'd1);
  endtask

  // Runs one operation starting at a negedge and ends at a negedge back in IDLE.
  // corrupt: keep start_valid high and scramble operands after acceptance.
  // holdCycles: extra cycles of res_ready=0 backpressure in DONE.
  task automatic applyStimulus(input vec_t v, input bit corrupt, input int holdCycles);
    int cycles;
    logic [15:0] heldResult;
    start_valid = 1'b1;
    op_a        = v.a;
    op_b        = v.b;
    mode        = v.mode;
    res_ready   = 1'b0;
    checkOutput({v.name, " start_ready before accept"}, 32'(start_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (corrupt) begin
      op_a = ~v.a;
      op_b = v.a ^ 16'h5A5A;
      mode = ~v.mode;
    end else begin
      start_valid = 1'b0;
    end
    checkOutput({v.name, " busy in run"}, 32'(busy), 32'd1);
    cycles = 0;
    while (!res_valid && cycles < 20) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    checkOutput({v.name, " latency"}, 32'(cycles), 32'd4);
    checkOutput({v.name, " result"}, 32'(result), 32'(v.expResult));
    checkOutput({v.name, " carry_out"}, 32'(carry_out), 32'(v.expC));
    checkOutput({v.name, " overflow"}, 32'(overflow), 32'(v.expV));
    checkOutput({v.name, " zero"}, 32'(zero), 32'(v.expZ));
    checkOutput({v.name, " start_ready in done"}, 32'(start_ready), 32'd0);
    heldResult = result;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({v.name, " held res_valid"}, 32'(res_valid), 32'd1);
      checkOutput({v.name, " held result"}, 32'(result), 32'(heldResult));
      checkOutput({v.name, " held start_ready"}, 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({v.name, " idle after handshake"}, 32'(start_ready), 32'd1);
    checkOutput({v.name, " res_valid after handshake"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int waitCycles;
    bit sawValid;

    checks   = 0;
    failures = 0;

    vecs[0] = '{"add 1234+0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"sub 0005-0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"sub abcd-abcd", 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"add 7fff+0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"sub 8000-0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{"add ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{"add 8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{"sub 0000-0001", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{"add 0001+0001", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};

    rst_n       = 1'b0;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    mode        = 1'b0;
    abort       = 1'b0;
    res_ready   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkResetValues("power-on reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table of arithmetic vectors; vector 2 also scrambles inputs after acceptance.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], (i == 2), 0);
    end

    // Backpressure for ten cycles, then a back-to-back op right after IDLE.
    $display("[TB] backpressure sequence");
    applyStimulus(vecs[0], 1'b0, 10);
    applyStimulus(vecs[4], 1'b1, 0);

    // Abort on the second RUN cycle, then show no stale carry leaks forward.
    $display("[TB] abort sequence");
    start_valid = 1'b1;
    op_a        = 16'hFFFF;
    op_b        = 16'hFFFF;
    mode        = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort start_ready", 32'(start_ready), 32'd1);
    checkOutput("abort busy", 32'(busy), 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid) sawValid = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort res_valid never rose", 32'(sawValid), 32'd0);
    applyStimulus(vecs[8], 1'b0, 0);

    // Reset while in RUN.
    $display("[TB] reset in run");
    start_valid = 1'b1;
    op_a        = 16'h1234;
    op_b        = 16'h0FFF;
    mode        = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetValues("reset in run");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while in DONE with a nonzero, overflowing result on the outputs.
    $display("[TB] reset in done");
    start_valid = 1'b1;
    op_a        = 16'h7FFF;
    op_b        = 16'h0001;
    mode        = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    waitCycles  = 0;
    while (!res_valid && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("reset in done reached done", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetValues("reset in done");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(vecs[1], 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
